// File: rtl/mux_8x1_rr_sched.sv
// mux_8x1_rr_sched: round-robin arbiter driving a shared 8:1 mux, with a per-grant hold limit.
// A release re-arbitrates on the same edge, so back-to-back grants have no idle bubble.
module mux_8x1_rr_sched #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] I,
    output logic [2:0] S,
    output logic [7:0] gnt,
    output logic       valid,
    output logic       Y
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [2:0] s_q, s_d, ptr_q, ptr_d, start, win;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic       found, keep;

    // On release the search begins just past the outgoing owner, which is exactly the new ptr.
    assign start = (state_q == GRANT) ? s_q + 3'd1 : ptr_q;
    assign keep  = (state_q == GRANT) && req[s_q] && (cnt_q < 4'(HOLD));

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (req[start + 3'(k)]) begin
                win   = start + 3'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        if (keep) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            ptr_d   = (state_q == GRANT) ? s_q + 3'd1 : ptr_q;
            state_d = found ? GRANT : IDLE;
            s_d     = found ? win : s_q;
            cnt_d   = found ? 4'd1 : 4'd0;
            gnt_d   = found ? 8'd1 << win : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign S     = s_q;
    assign gnt   = gnt_q;
    assign valid = (state_q == GRANT);
    assign Y     = valid & I[s_q];
endmodule

// File: doc/mux_8x1_rr_sched.md
MUX_8X1_RR_SCHED -- requirements
Module: mux_8x1_rr_sched

Interface
REQ-001 Parameter: HOLD, default 4, maximum consecutive cycles one requester may hold the grant; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req  input  8  request vector; req[k]=1 means requester k wants the shared mux.
REQ-005 I  input  8  data inputs; I[k] belongs to requester k.
REQ-006 S  output  3  registered select; index of the requester currently granted.
REQ-007 gnt  output  8  registered one-hot grant; equals 1<<S while valid=1, otherwise 8'h00.
REQ-008 valid  output  1  high while a grant is active (state GRANT).
REQ-009 Y  output  1  muxed data; combinational I[S] when valid=1, otherwise 0.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-011 The block SHALL keep internal registers ptr[2:0] (next search start) and cnt[3:0] (cycles held in the current grant).
REQ-012 Arbitration SHALL be round-robin: search order ptr, ptr+1, ..., ptr+7 modulo 8; the first index with req set wins.
REQ-013 In IDLE, if any req bit is set at a rising edge, the block SHALL enter GRANT at that edge with S=winner, gnt=1<<winner and cnt=1; grant is visible one cycle after req is sampled.
REQ-014 In IDLE, if req=8'h00, the block SHALL remain in IDLE with gnt=0 and valid=0, and S SHALL hold its last value.
REQ-015 In GRANT, if req[S]=1 and cnt<HOLD, the block SHALL stay in GRANT, keep S and gnt unchanged, and increment cnt.
REQ-016 In GRANT, release SHALL occur at the edge where req[S]=0 or cnt==HOLD; ptr SHALL load (S+1) mod 8 (7 wraps to 0).
REQ-017 On release, the block SHALL re-arbitrate in the same edge from the new ptr using the current req vector.
REQ-018 If the re-arbitration finds a winner, the block SHALL go directly to GRANT with no bubble cycle: new S, new gnt, cnt=1.
REQ-019 If the re-arbitration finds no winner, the block SHALL go to IDLE with gnt=0 and valid=0.
REQ-020 If only the current owner still requests when HOLD expires, it SHALL be re-granted (search wraps back to S), cnt=1.
REQ-021 Y SHALL follow I[S] combinationally, with zero latency, while valid=1; changes on I[k] with k≠S SHALL not affect Y.
REQ-022 At most one gnt bit SHALL ever be set; gnt and valid SHALL always be consistent with the state.
REQ-023 No requester with req held high SHALL wait more than 7*HOLD cycles for a grant.

Reset
REQ-024 While rst=1 at a rising edge, the block SHALL set state=IDLE, S=0, gnt=8'h00, valid=0, ptr=0 and cnt=0; Y is therefore 0.
REQ-025 Reset SHALL take priority over any grant in progress; the first arbitration after rst deasserts SHALL start from ptr=0.

Verification
REQ-026 Reset with req=8'h00 held for 3 cycles -> gnt=8'h00, valid=0, S=0, Y=0 in every cycle.
REQ-027 HOLD=4, req=8'h04 held, I=8'h04 -> one edge later S=2, gnt=8'h04, valid=1, Y=1; after 4 cycles requester 2 is re-granted back-to-back with valid continuously high.
REQ-028 HOLD=4, req=8'hFF held -> grants 0,1,2,...,7,0 in order, each exactly 4 cycles, valid never drops.
REQ-029 Grant on 5 with req=8'h60; drop req[5] after 2 cycles -> at the next edge S=6, gnt=8'h40; if req=8'h00 instead -> IDLE, valid=0.
REQ-030 Assert rst mid-grant on requester 3, then release with req=8'h81 -> outputs clear at the reset edge; first grant after release is S=0, and the next is S=7.
REQ-031 Grant on 3: toggle I[3] -> Y toggles in the same cycle; toggle I[6] -> Y unchanged.
